// File: rtl/cheshire_pwm_ctrl.sv
// cheshire_pwm_ctrl: N-channel PWM with prescaler and valid/ready config; define CHESHIRE_PWM_RAMP_EN for soft-start duty ramping
module cheshire_pwm_ctrl #(
  parameter int NumChannels   = 2,
  parameter int CntWidth      = 8,
  parameter int PrescaleWidth = 16,
  parameter int AddrWidth     = $clog2(NumChannels + 1),
  parameter int DataWidth     = (CntWidth > PrescaleWidth) ? CntWidth : PrescaleWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [AddrWidth-1:0]   cfg_addr_i,
  input  logic [DataWidth-1:0]   cfg_data_i,
  output logic [NumChannels-1:0] pwm_o,
  output logic                   period_tick_o,
  output logic                   busy_o
);
  typedef enum logic [1:0] {OFF, RUN, STOP} state_e;
  localparam logic [CntWidth-1:0]  LAST     = {{(CntWidth-1){1'b1}}, 1'b0};
  localparam logic [AddrWidth-1:0] PSC_ADDR = AddrWidth'(NumChannels);
  state_e                   state, state_n;
  logic [PrescaleWidth-1:0] prescale_q, psc_cnt;
  logic [CntWidth-1:0]      per_cnt;
  logic [CntWidth-1:0]      tgt_duty [NumChannels];
  logic [CntWidth-1:0]      cur_duty [NumChannels];
  logic                     run, tick, wrap, wr;
  always_comb begin
    run     = state != OFF;
    tick    = run && psc_cnt == prescale_q;
    wrap    = tick && per_cnt == LAST;
    wr      = cfg_valid_i && cfg_ready_o;
    state_n = !run ? (en_i ? RUN : OFF) : en_i ? RUN : (state == STOP && wrap) ? OFF : STOP;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= OFF;
      cfg_ready_o   <= 1'b0;
      pwm_o         <= '0;
      period_tick_o <= 1'b0;
      busy_o        <= 1'b0;
      prescale_q    <= '0;
      psc_cnt       <= '0;
      per_cnt       <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        tgt_duty[c] <= '0;
        cur_duty[c] <= '0;
      end
    end else begin
      state         <= state_n;
      cfg_ready_o   <= 1'b1;
      period_tick_o <= wrap;
      busy_o        <= state_n != OFF;
      psc_cnt       <= (!run || psc_cnt >= prescale_q) ? '0 : psc_cnt + 1'b1;
      per_cnt       <= (!run || wrap) ? '0 : tick ? per_cnt + 1'b1 : per_cnt;
      if (wr && cfg_addr_i == PSC_ADDR) prescale_q <= cfg_data_i[PrescaleWidth-1:0];
      for (int c = 0; c < NumChannels; c++) begin
        pwm_o[c] <= run && state_n != OFF && per_cnt < cur_duty[c];
        if (wr && cfg_addr_i == AddrWidth'(c)) tgt_duty[c] <= cfg_data_i[CntWidth-1:0];
`ifdef CHESHIRE_PWM_RAMP_EN
        if (wrap) cur_duty[c] <= cur_duty[c] < tgt_duty[c] ? cur_duty[c] + 1'b1 :
                                 cur_duty[c] > tgt_duty[c] ? cur_duty[c] - 1'b1 : cur_duty[c];
`else
        if (wrap || (!run && en_i)) cur_duty[c] <= tgt_duty[c];
`endif
      end
    end
  end
endmodule
